div_share_ctrl: RTL and testbench

//  Controller and round-robin arbiter that shares one 33-cycle iterative 32-bit divider between two requesters (A, B).

---
 rtl/div_share_ctrl.sv | 146 ++++++++++++++
 tb/tb_div_share_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one iterative 32-bit divider between requesters A and B.
// Optional feature macro DIV_SHARE_ZCHK_EN: answer zero-divisor requests directly without using the divider.
module div_share_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        r,
    input  logic        req_valid_a,
    output logic        req_ready_a,
    input  logic [31:0] dend_a,
    input  logic [31:0] dsor_a,
    input  logic        req_valid_b,
    output logic        req_ready_b,
    input  logic [31:0] dend_b,
    input  logic [31:0] dsor_b,
    output logic        div_start,
    output logic [31:0] div_dend,
    output logic [31:0] div_dsor,
    input  logic [31:0] div_q,
    input  logic [30:0] div_rem,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_q,
    output logic [30:0] rsp_rem,
    output logic        rsp_dz,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;   // 1 = B was served last
    logic [CNT_W-1:0] cnt;
    logic             grant_a;
    logic             grant_b;
    logic             accept;
    logic             sel_id;
    logic [31:0]      sel_dend;
    logic [31:0]      sel_dsor;
    logic             zero_skip;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == S_IDLE) begin
            grant_a = req_valid_a && (!req_valid_b || last_grant);
            grant_b = req_valid_b && (!req_valid_a || !last_grant);
        end
    end

    assign req_ready_a = grant_a;
    assign req_ready_b = grant_b;
    assign accept      = grant_a || grant_b;
    assign sel_id      = grant_b;
    assign sel_dend    = grant_b ? dend_b : dend_a;
    assign sel_dsor    = grant_b ? dsor_b : dsor_a;

`ifdef DIV_SHARE_ZCHK_EN
    assign zero_skip = (sel_dsor == 32'd0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = zero_skip ? S_RESP : S_LAUNCH;
            S_LAUNCH:  state_nxt = S_WAIT;
            S_WAIT:    if (cnt == CNT_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_RESP;
            S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) last_grant <= sel_id;
            if (state == S_LAUNCH)
                cnt <= '0;
            else if (state == S_WAIT)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Operands stay on the divider inputs until the next accept.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            div_dend <= '0;
            div_dsor <= '0;
            rsp_id   <= 1'b0;
        end else if (accept) begin
            div_dend <= sel_dend;
            div_dsor <= sel_dsor;
            rsp_id   <= sel_id;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            rsp_q   <= '0;
            rsp_rem <= '0;
        end else if (state == S_CAPTURE) begin
            rsp_q   <= div_q;
            rsp_rem <= div_rem;
        end else if (accept && zero_skip) begin
            rsp_q   <= 32'hFFFF_FFFF;
            rsp_rem <= sel_dend[30:0];
        end
    end

`ifdef DIV_SHARE_ZCHK_EN
    always_ff @(posedge clk or negedge r) begin
        if (!r)
            rsp_dz <= 1'b0;
        else if (state == S_CAPTURE)
            rsp_dz <= 1'b0;
        else if (accept && zero_skip)
            rsp_dz <= 1'b1;
    end
`else
    assign rsp_dz = 1'b0;
`endif

    assign div_start = (state == S_LAUNCH);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl with a stand-in iterative divider and a transaction-level model.
module tb_div_share_ctrl;

    localparam int DIV_CYCLES = 33;
    localparam int LAT        = 3 + DIV_CYCLES;
`ifdef DIV_SHARE_ZCHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r = 1'b0;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_ready_a, req_ready_b;
    logic [31:0] dend_a = '0, dsor_a = '0, dend_b = '0, dsor_b = '0;
    logic        div_start;
    logic [31:0] div_dend, div_dsor, div_q;
    logic [30:0] div_rem;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_dz, busy;
    logic [31:0] rsp_q;
    logic [30:0] rsp_rem;

    int n_checks = 0;
    int n_fail   = 0;

    div_share_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
        .clk(clk), .r(r),
        .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .dend_a(dend_a), .dsor_a(dsor_a),
        .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .dend_b(dend_b), .dsor_b(dsor_b),
        .div_start(div_start), .div_dend(div_dend), .div_dsor(div_dsor),
        .div_q(div_q), .div_rem(div_rem),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in divider: result only becomes correct DIV_CYCLES cycles after the start pulse.
    int dcnt = 100;
    always @(posedge clk) begin
        if (div_start) dcnt <= 0;
        else if (dcnt < 100) dcnt <= dcnt + 1;
    end

    always_comb begin
        div_q   = 32'hDEAD_BEEF ^ 32'(dcnt);
        div_rem = 31'h1234_5678 ^ 31'(dcnt);
        if (dcnt >= DIV_CYCLES) begin
            if (div_dsor == 32'd0) begin
                div_q   = 32'hFFFF_FFFF;
                div_rem = div_dend[30:0];
            end else begin
                div_q   = div_dend / div_dsor;
                div_rem = 31'(div_dend % div_dsor);
            end
        end
    end

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [30:0] rm);
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            rm = a[30:0];
        end else begin
            q  = a / b;
            rm = 31'(a % b);
        end
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output int lat, output int starts, output int rdy);
        starts = 0;
        rdy    = 0;
        lat    = -1;
        for (int i = 1; i <= 200; i++) begin
            if (div_start) starts++;
            if (req_ready_a || req_ready_b) rdy++;
            if (rsp_valid) begin
                lat = i;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_rsp(input string nm, input int hold);
        logic [65:0] snap;
        snap = {rsp_valid, rsp_id, rsp_q, rsp_rem, rsp_dz};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_hold"},
                  128'({rsp_valid, rsp_id, rsp_q, rsp_rem, rsp_dz, req_ready_a, req_ready_b, div_start}),
                  128'({snap, 3'b000}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({nm, "_drop"}, 128'(rsp_valid), 128'(1'b0));
    endtask

    task automatic serve(input string nm, input bit exp_id, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        int          lat, starts, rdy;
        logic [31:0] eq;
        logic [30:0] er;
        bit          skip;
        skip = ZCHK && (b == 32'd0);
        ref_div(a, b, eq, er);
        wait_rsp(lat, starts, rdy);
        check({nm, "_lat"},    128'(lat),    128'(skip ? 1 : LAT));
        check({nm, "_starts"}, 128'(starts), 128'(skip ? 0 : 1));
        check({nm, "_ready"},  128'(rdy),    128'(0));
        check({nm, "_rsp"}, 128'({rsp_id, rsp_q, rsp_rem, rsp_dz}), 128'({exp_id, eq, er, skip}));
        release_rsp(nm, hold);
    endtask

    initial begin
        int          cnt_bad;
        bit          pa, pb, g, lg;
        logic [31:0] ea, sa, eb, sb;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", 128'({busy, rsp_valid, div_start, req_ready_a, req_ready_b, rsp_id, rsp_dz}),
              128'(7'd0));
        check("reset_data", 128'({rsp_q, rsp_rem, div_dend, div_dsor}), 128'(0));
        r = 1'b1;

        // contention right after reset: A first, then B on the first idle cycle
        @(posedge clk); #1;
        req_valid_a = 1'b1; dend_a = 32'd1000; dsor_a = 32'd7;
        req_valid_b = 1'b1; dend_b = 32'd999;  dsor_b = 32'd10;
        #1;
        check("c1_grant", 128'({req_ready_a, req_ready_b}), 128'(2'b10));
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        serve("c1_a", 1'b0, 32'd1000, 32'd7, 0);
        check("c1_b_idle", 128'({req_ready_a, req_ready_b}), 128'(2'b01));
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        serve("c1_b", 1'b1, 32'd999, 32'd10, 0);

        // A alone
        req_valid_a = 1'b1; dend_a = 32'd57821254; dsor_a = 32'd5468;
        #1;
        check("a_grant", 128'({req_ready_a, req_ready_b}), 128'(2'b10));
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        check("a_start_t1", 128'({div_start, busy, div_dend, div_dsor}),
              128'({2'b11, 32'd57821254, 32'd5468}));
        serve("a_only", 1'b0, 32'd57821254, 32'd5468, 0);
        check("a_known", 128'({rsp_q, rsp_rem}), 128'({32'd10574, 31'd2622}));

        // contention after A served: B first with 10 cycles of backpressure, then A
        req_valid_a = 1'b1; dend_a = 32'hFFFF_FFFF; dsor_a = 32'd3;
        req_valid_b = 1'b1; dend_b = 32'h8000_0001; dsor_b = 32'h7FFF_FFFF;
        #1;
        check("c2_grant", 128'({req_ready_a, req_ready_b}), 128'(2'b01));
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        serve("c2_b", 1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 10);
        check("c2_a_idle", 128'({req_ready_a, req_ready_b}), 128'(2'b10));
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        serve("c2_a", 1'b0, 32'hFFFF_FFFF, 32'd3, 0);
        check("hold_idle", 128'({div_dend, div_dsor}), 128'({32'hFFFF_FFFF, 32'd3}));

        // divisor zero from B
        req_valid_b = 1'b1; dend_b = 32'd100; dsor_b = 32'd0;
        #1;
        check("dz_grant", 128'({req_ready_a, req_ready_b}), 128'(2'b01));
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        serve("dz", 1'b1, 32'd100, 32'd0, 0);

        // reset in the middle of WAIT discards the operation
        req_valid_a = 1'b1; dend_a = 32'd12345; dsor_a = 32'd3;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", 128'(busy), 128'(1'b1));
        r = 1'b0;
        #1;
        check("rst_async", 128'({busy, rsp_valid, div_start}), 128'(3'b000));
        @(posedge clk); #1;
        check("rst_edge", 128'({busy, rsp_valid, div_start}), 128'(3'b000));
        r = 1'b1;
        cnt_bad = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (rsp_valid || busy || div_start) cnt_bad++;
        end
        check("rst_no_rsp", 128'(cnt_bad), 128'(0));

        // randomized traffic against the round-robin transaction model
        lg = 1'b1; pa = 1'b0; pb = 1'b0;
        ea = '0; sa = '0; eb = '0; sb = '0;
        for (int t = 0; t < 24; t++) begin
            if (!pa && ($urandom_range(0, 1) == 1 || !pb)) begin
                pa = 1'b1;
                ea = $urandom;
                sa = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom >> $urandom_range(1, 30)) | 32'd1);
            end
            if (!pb && $urandom_range(0, 1) == 1) begin
                pb = 1'b1;
                eb = $urandom;
                sb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom >> $urandom_range(1, 30)) | 32'd1);
            end
            req_valid_a = pa; dend_a = ea; dsor_a = sa;
            req_valid_b = pb; dend_b = eb; dsor_b = sb;
            #1;
            g = (pa && pb) ? !lg : pb;
            check("rnd_grant", 128'({req_ready_a, req_ready_b}), 128'(g ? 2'b01 : 2'b10));
            @(posedge clk); #1;
            if (g) begin pb = 1'b0; req_valid_b = 1'b0; end
            else   begin pa = 1'b0; req_valid_a = 1'b0; end
            lg = g;
            serve("rnd", g, g ? eb : ea, g ? sb : sa, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
